// File: rtl/pc_redirect_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_if
// Brief   : EX-stage redirect inputs, fetch handshake and redirect status.
// Revision: 1.0 - initial release
// ============================================================================
interface pc_redirect_if #(
    parameter int CNT_W = 32
) ();
    logic             ex_valid;
    logic             ex_jump_flag;
    logic             ex_is_branch;
    logic [31:0]      ex_next_pc;
    logic             stall;
    logic             fetch_ready;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_if;
    logic             flush_id;
    logic             misalign_exc;
    logic             busy;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    // Pipeline/fetch side: drives EX results and fetch acceptance
    modport master (
        output ex_valid, ex_jump_flag, ex_is_branch, ex_next_pc, stall, fetch_ready,
        input  redirect_valid, redirect_pc, flush_if, flush_id, misalign_exc, busy,
               branch_count, taken_count
    );

    modport slave (
        input  ex_valid, ex_jump_flag, ex_is_branch, ex_next_pc, stall, fetch_ready,
        output redirect_valid, redirect_pc, flush_if, flush_id, misalign_exc, busy,
               branch_count, taken_count
    );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pc_redirect_ctrl
// Brief   : Captures taken EX branches/jumps, hands the target to fetch and
//           holds IF/ID flush until wrong-path instructions have drained.
// Revision: 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    pc_redirect_if.slave bus
);

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_flush_cnt, w_flush_cnt_nxt;
    logic               r_redirect_valid, w_redirect_valid_nxt;
    logic [31:0]        r_redirect_pc, w_redirect_pc_nxt;
    logic               r_misalign, w_misalign_nxt;
    logic               r_busy, w_busy_nxt;
    logic [CNT_W-1:0]   r_branch_cnt, w_branch_cnt_nxt;
    logic [CNT_W-1:0]   r_taken_cnt, w_taken_cnt_nxt;

    logic w_idle;
    logic w_ex_live;
    logic w_trigger;
    logic w_branch_seen;

    // While busy, anything in EX is wrong-path and must be ignored entirely
    assign w_idle        = (r_state == S_IDLE);
    assign w_ex_live     = bus.ex_valid & ~bus.stall & w_idle;
    assign w_trigger     = w_ex_live & bus.ex_jump_flag;
    assign w_branch_seen = w_ex_live & bus.ex_is_branch;

    always_comb begin
        w_state_nxt          = r_state;
        w_flush_cnt_nxt      = r_flush_cnt;
        w_redirect_valid_nxt = r_redirect_valid;
        w_redirect_pc_nxt    = r_redirect_pc;
        w_misalign_nxt       = 1'b0;
        w_branch_cnt_nxt     = r_branch_cnt;
        w_taken_cnt_nxt      = r_taken_cnt;

        if (w_branch_seen) begin
            w_branch_cnt_nxt = r_branch_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    if (bus.ex_next_pc[1:0] == 2'b00) begin
                        w_redirect_pc_nxt    = bus.ex_next_pc;
                        w_redirect_valid_nxt = 1'b1;
                        w_state_nxt          = S_PEND;
                    end else begin
                        w_misalign_nxt = 1'b1;
                    end
                end
            end
            S_PEND: begin
                if (r_redirect_valid && bus.fetch_ready) begin
                    w_redirect_valid_nxt = 1'b0;
                    w_flush_cnt_nxt      = c_FLUSH_LOAD;
                    w_taken_cnt_nxt      = r_taken_cnt + 1'b1;
                    w_state_nxt          = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                if (r_flush_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt          = S_IDLE;
                w_redirect_valid_nxt = 1'b0;
            end
        endcase

        // Flush and busy share one registered source: both track non-IDLE
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_flush_cnt      <= 4'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_misalign       <= 1'b0;
            r_busy           <= 1'b0;
            r_branch_cnt     <= '0;
            r_taken_cnt      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_flush_cnt      <= w_flush_cnt_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
            r_misalign       <= w_misalign_nxt;
            r_busy           <= w_busy_nxt;
            r_branch_cnt     <= w_branch_cnt_nxt;
            r_taken_cnt      <= w_taken_cnt_nxt;
        end
    end

    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush_if       = r_busy;
    assign bus.flush_id       = r_busy;
    assign bus.misalign_exc   = r_misalign;
    assign bus.busy           = r_busy;
    assign bus.branch_count   = r_branch_cnt;
    assign bus.taken_count    = r_taken_cnt;

endmodule
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Sequences control-flow redirects produced by the EX-stage branch/jump evaluator of the 5-stage RV32I pipeline. Captures a taken branch or jump and its target, and presents the target to the fetch unit over a valid/ready handshake. Holds IF/ID flush asserted until the wrong-path instructions have drained. It also detects misaligned targets and keeps redirect statistics.

Parameters:
FLUSH_DEPTH, 2, cycles flush stays asserted after the fetch unit accepts the redirect (legal range 1..15)
CNT_W, 32, width of the statistics counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX stage holds a valid instruction this cycle
ex_jump_flag  input  1  branch condition true, or unconditional jump, from the branch evaluator
ex_is_branch  input  1  EX instruction is a branch or jump (taken or not)
ex_next_pc  input  32  computed target from the branch evaluator
stall  input  1  pipeline stall from the hazard unit; EX contents are re-presented next cycle
fetch_ready  input  1  fetch unit accepts a redirect this cycle
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  32  target address, stable while redirect_valid=1
flush_if  output  1  squash the IF/ID register
flush_id  output  1  squash the ID/EX register
misalign_exc  output  1  one-cycle pulse: taken target not 4-byte aligned
busy  output  1  state != IDLE
branch_count  output  CNT_W  branches/jumps retired from EX
taken_count  output  CNT_W  redirects issued

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, all outputs and state are 0: state IDLE, redirect_pc=0, counters=0. Reset asserted mid-redirect abandons the redirect immediately; there is no pending state after release.
- All outputs are registered.
- Trigger condition: ex_valid & ~stall & ex_jump_flag & state==IDLE.
- State IDLE:
  - On a trigger with ex_next_pc[1:0]==0: redirect_pc<=ex_next_pc, redirect_valid<=1, flush_if<=1, flush_id<=1, go to PEND. Outputs are visible in the cycle after the trigger edge (latency 1).
  - On a trigger with ex_next_pc[1:0]!=0: misalign_exc<=1 for exactly one cycle. No redirect, no flush, stay IDLE, taken_count unchanged.
- State PEND: redirect_valid, redirect_pc, flush_if and flush_id are all held.
  - On an edge with redirect_valid & fetch_ready: redirect_valid<=0, load the flush counter with FLUSH_DEPTH, go to FLUSH.
  - redirect_pc must not change while in PEND. Back-pressure of any length is legal.
- State FLUSH: flush_if=flush_id=1. The counter decrements each edge. On the edge where the counter equals 1: go to IDLE, and both flushes drop.
- Flush duration: flush is high for (PEND cycles)+FLUSH_DEPTH cycles in total.
- busy=1 in PEND and FLUSH.
- Triggers while busy are ignored; they are wrong-path instructions. This includes no counter update.
- Stall gating: ex_valid with stall=1 causes no trigger and no counting. The instruction is counted once, when stall drops.
- branch_count increments when ex_valid & ~stall & ex_is_branch & state==IDLE.
- taken_count increments on each accepted redirect handshake.
- Both counters wrap modulo 2^CNT_W with no saturation. When a branch is counted and its redirect accepted on the same edge, both counters increment.
- Rejected conditions: misalign_exc and redirect_valid are never high in the same cycle.

Test Plan:
1. Reset, then a single taken branch: ex_valid=1, ex_jump_flag=1, ex_next_pc=0x0000_0100, fetch_ready=1. Required: next cycle redirect_valid=1, redirect_pc=0x100, flush high. FLUSH_DEPTH=2, so flush is high for exactly 3 cycles total. Afterwards taken_count=1 and branch_count=1.
2. Back-pressure: same trigger with fetch_ready=0 for 4 cycles, then 1. Required: redirect_valid and redirect_pc=0x100 held stable for 5 cycles; flush high for 7 cycles. A second trigger (target 0x200) during PEND is ignored and branch_count does not increment for it.
3. Misaligned target: trigger with ex_next_pc=0x0000_0102. Required: misalign_exc pulses for 1 cycle; redirect_valid=0; flush=0; busy=0; taken_count unchanged.
4. Stall gating: trigger held for 3 cycles with stall=1, then stall=0. Required: no redirect during the stall; one redirect issued the cycle after stall drops; branch_count increments by exactly 1.
5. Not-taken branch: ex_is_branch=1, ex_jump_flag=0. Required: branch_count+1, taken_count unchanged, no flush.
6. Reset mid-PEND with rst_n=0 asynchronously. Required: redirect_valid, flush and busy go to 0 without a clock edge. After release the block is IDLE and the first trigger behaves as in test 1.
7. Counter wrap with CNT_W=4: issue 16 accepted redirects. Required: taken_count returns to 0.
